tlc_phase_sched: RTL and testbench

//  Timed phase sequencer for the two-road traffic light.
//  - Drives lights La (road A) and Lb (road B) from sensors Ta/Tb.
//  - Adds yellow timing, minimum-green timing and a max-green anti-starvation limit.
//  - Optional all-red pedestrian walk phase.
//  - Sits between the sensor inputs and the lamp drivers; replaces the untimed next-state logic.

---
 rtl/tlc_pkg.sv | 25 ++
 rtl/tlc_phase_timer.sv | 31 +++
 rtl/tlc_phase_sched.sv | 160 ++++++++++++++++
 tb/tb_tlc_phase_sched.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : tlc_pkg                                                   |
// | Purpose  : Shared lamp codes and phase encodings for the two-road    |
// |            traffic-light phase sequencer.                            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package tlc_pkg;

    // Lamp drive codes (one per road)
    typedef logic [1:0] lamp_t;
    localparam lamp_t LAMP_G = 2'b00;
    localparam lamp_t LAMP_Y = 2'b01;
    localparam lamp_t LAMP_R = 2'b10;

    // Phase encodings; 5..7 are unused and recover to S_AG
    typedef logic [2:0] state_t;
    localparam state_t S_AG   = 3'd0;
    localparam state_t S_AY   = 3'd1;
    localparam state_t S_BG   = 3'd2;
    localparam state_t S_BY   = 3'd3;
    localparam state_t S_WALK = 3'd4;

endpackage
`default_nettype wire

// File: rtl/tlc_phase_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tlc_phase_timer                                           |
// | Purpose  : Cycles-since-phase-entry counter. Saturates at all-ones   |
// |            so long dwell times never wrap back below a threshold.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tlc_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Clear on reset or phase change, otherwise count up and hold at max
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (r_cnt != {CNT_W{1'b1}}) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/tlc_phase_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tlc_phase_sched                                           |
// | Purpose  : Timed phase sequencer for a two-road traffic light with   |
// |            yellow timing, minimum green, max-green anti-starvation   |
// |            and an optional all-red pedestrian walk phase.            |
// | Config   : define PED_WALK_EN to build the pedestrian walk phase.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tlc_phase_sched
    import tlc_pkg::*;
#(
    parameter int YELLOW_CYC    = 5,
    parameter int MIN_GREEN_CYC = 10,
    parameter int MAX_GREEN_CYC = 60,
    parameter int WALK_CYC      = 20,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Ta,
    input  logic       Tb,
    input  logic       ped_req,
    output logic [1:0] La,
    output logic [1:0] Lb,
    output logic       walk,
    output logic [2:0] state
);

    // Last counter value of each timed interval (cnt is 0 on phase entry)
    localparam logic [CNT_W-1:0] c_yel_last  = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] c_min_last  = CNT_W'(MIN_GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] c_max_last  = CNT_W'(MAX_GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] c_walk_last = CNT_W'(WALK_CYC - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] w_cnt;
    logic             w_clr;
    logic             w_ped_pend;
    lamp_t            w_la;
    lamp_t            w_lb;
    logic             w_walk;

    // Phase counter restarts whenever the phase changes
    assign w_clr = (w_next != r_state);

    tlc_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk (clk),
        .rst (reset),
        .clr (w_clr),
        .cnt (w_cnt)
    );

`ifdef PED_WALK_EN
    logic r_ped_pend;
    logic r_next_road;   // 1: walk resumes on road B green, 0: road A green

    // Latch pedestrian requests outside the walk phase; entry to walk consumes it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ped_pend <= 1'b0;
        end else if ((w_next == S_WALK) && (r_state != S_WALK)) begin
            r_ped_pend <= 1'b0;
        end else if (ped_req && (r_state != S_WALK)) begin
            r_ped_pend <= 1'b1;
        end
    end

    // Remember which green the interrupted yellow was heading to
    always_ff @(posedge clk) begin
        if (reset) begin
            r_next_road <= 1'b0;
        end else if ((w_next == S_WALK) && (r_state == S_AY)) begin
            r_next_road <= 1'b1;
        end else if ((w_next == S_WALK) && (r_state == S_BY)) begin
            r_next_road <= 1'b0;
        end
    end

    assign w_ped_pend = r_ped_pend;
`else
    assign w_ped_pend = 1'b0;

    // Walk feature absent: request input and walk timing are intentionally unused
    logic w_unused;
    assign w_unused = ^{ped_req, c_walk_last, w_ped_pend};
`endif

    // Phase register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_AG;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-phase selection and lamp decode from the registered phase only
    always_comb begin
        w_next = r_state;
        w_la   = LAMP_R;
        w_lb   = LAMP_R;
        w_walk = 1'b0;
        case (r_state)
            S_AG: begin
                w_la = LAMP_G;
                if ((w_cnt >= c_min_last) && (!Ta || (Tb && (w_cnt >= c_max_last)))) begin
                    w_next = S_AY;
                end
            end
            S_AY: begin
                w_la = LAMP_Y;
                if (w_cnt == c_yel_last) begin
`ifdef PED_WALK_EN
                    w_next = w_ped_pend ? S_WALK : S_BG;
`else
                    w_next = S_BG;
`endif
                end
            end
            S_BG: begin
                w_lb = LAMP_G;
                if ((w_cnt >= c_min_last) && (!Tb || (Ta && (w_cnt >= c_max_last)))) begin
                    w_next = S_BY;
                end
            end
            S_BY: begin
                w_lb = LAMP_Y;
                if (w_cnt == c_yel_last) begin
`ifdef PED_WALK_EN
                    w_next = w_ped_pend ? S_WALK : S_AG;
`else
                    w_next = S_AG;
`endif
                end
            end
`ifdef PED_WALK_EN
            S_WALK: begin
                w_walk = 1'b1;
                if (w_cnt == c_walk_last) begin
                    w_next = r_next_road ? S_BG : S_AG;
                end
            end
`endif
            default: begin
                w_next = S_AG;
            end
        endcase
    end

    assign La    = w_la;
    assign Lb    = w_lb;
    assign walk  = w_walk;
    assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_tlc_phase_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_tlc_phase_sched                                        |
// | Purpose  : Self-checking bench for tlc_phase_sched: reference model  |
// |            of the phase rules compared every cycle, plus directed    |
// |            literal expectations. Honours PED_WALK_EN.                |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_tlc_phase_sched;

    localparam int YEL  = 5;
    localparam int MING = 10;
    localparam int MAXG = 60;
    localparam int WLK  = 20;
`ifdef PED_WALK_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       Ta;
    logic       Tb;
    logic       ped_req;
    logic [1:0] La;
    logic [1:0] Lb;
    logic       walk;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    tlc_phase_sched dut (
        .clk     (clk),
        .reset   (reset),
        .Ta      (Ta),
        .Tb      (Tb),
        .ped_req (ped_req),
        .La      (La),
        .Lb      (Lb),
        .walk    (walk),
        .state   (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: phase index 0=A green,1=A yellow,2=B green,3=B yellow,4=walk;
    // m_el counts cycles spent in the phase including the current one.
    int m_phase = 0;
    int m_el    = 1;
    bit m_pend  = 1'b0;
    bit m_road  = 1'b0;
    bit m_valid = 1'b0;

    function automatic int lamp_a(input int ph);
        return (ph == 0) ? 0 : (ph == 1) ? 1 : 2;
    endfunction

    function automatic int lamp_b(input int ph);
        return (ph == 2) ? 0 : (ph == 3) ? 1 : 2;
    endfunction

    // Advance the model on each rising edge using the inputs held at that edge
    always @(posedge clk) begin
        int nx;
        bit np;
        bit nr;
        if (reset) begin
            m_phase <= 0;
            m_el    <= 1;
            m_pend  <= 1'b0;
            m_road  <= 1'b0;
            m_valid <= 1'b1;
        end else if (m_valid) begin
            nx = m_phase;
            np = m_pend;
            nr = m_road;
            case (m_phase)
                0: if (m_el >= MING && (!Ta || (Tb && m_el >= MAXG))) nx = 1;
                1: if (m_el == YEL) begin
                       if (PED && m_pend) begin nx = 4; nr = 1'b1; end
                       else nx = 2;
                   end
                2: if (m_el >= MING && (!Tb || (Ta && m_el >= MAXG))) nx = 3;
                3: if (m_el == YEL) begin
                       if (PED && m_pend) begin nx = 4; nr = 1'b0; end
                       else nx = 0;
                   end
                default: if (m_el == WLK) nx = m_road ? 2 : 0;
            endcase
            if (PED && ped_req && m_phase != 4) np = 1'b1;
            if (nx == 4 && m_phase != 4) np = 1'b0;
            m_phase <= nx;
            m_el    <= (nx != m_phase) ? 1 : m_el + 1;
            m_pend  <= np;
            m_road  <= nr;
        end
    end

    // Compare DUT outputs against the model shortly after every rising edge
    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            chk("model_state", state, m_phase);
            chk("model_La", La, lamp_a(m_phase));
            chk("model_Lb", Lb, lamp_b(m_phase));
            chk("model_walk", walk, (m_phase == 4) ? 1 : 0);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input string nm);
        for (int k = 0; k < 300 && state !== s; k++) @(negedge clk);
        chk(nm, state, s);
    endtask

    initial begin
        reset   = 1'b1;
        Ta      = 1'b0;
        Tb      = 1'b0;
        ped_req = 1'b0;

        // Road A demand only: A green holds indefinitely
        Ta = 1'b1; Tb = 1'b0;
        do_reset();
        chk("rst_state", state, 0);
        chk("rst_La", La, 0);
        chk("rst_Lb", Lb, 2);
        chk("rst_walk", walk, 0);
        repeat (100) @(negedge clk);
        chk("hold_state", state, 0);
        chk("hold_La", La, 0);
        chk("hold_Lb", Lb, 2);
        // Walk to B yellow, then reset mid-phase
        Ta = 1'b0; Tb = 1'b1;
        wait_state(3'd2, "reach_BG");
        Ta = 1'b1; Tb = 1'b0;
        wait_state(3'd3, "reach_BY");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midBY_reset_state", state, 0);
        chk("midBY_reset_La", La, 0);
        reset = 1'b0;

        // Road B demand only: 10-cycle A green, 5-cycle yellow, then B green
        Ta = 1'b0; Tb = 1'b1;
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 9)  chk("ag_last_cycle", state, 0);
            if (i == 10) begin chk("ay_first", state, 1); chk("ay_La", La, 1); end
            if (i == 14) chk("ay_last_cycle", state, 1);
            if (i == 15) begin
                chk("bg_state", state, 2);
                chk("bg_La", La, 2);
                chk("bg_Lb", Lb, 0);
            end
        end

        // Both roads busy: greens alternate every 60 cycles
        Ta = 1'b1; Tb = 1'b1;
        do_reset();
        for (int i = 1; i <= 130; i++) begin
            @(negedge clk);
            if (i == 59)  chk("maxg_ag_last", state, 0);
            if (i == 60)  chk("maxg_ay", state, 1);
            if (i == 64)  chk("maxg_ay_last", state, 1);
            if (i == 65)  chk("maxg_bg", state, 2);
            if (i == 124) chk("maxg_bg_last", state, 2);
            if (i == 125) chk("maxg_by", state, 3);
            if (i == 130) chk("maxg_ag_again", state, 0);
        end

        // Single-cycle pedestrian pulse during A green
        Ta = 1'b0; Tb = 1'b1;
        do_reset();
        for (int i = 1; i <= 36; i++) begin
            @(negedge clk);
            if (i == 2) ped_req = 1'b1;
            if (i == 3) ped_req = 1'b0;
            if (i == 15) begin
                chk("ped_state", state, PED ? 4 : 2);
                chk("ped_walk", walk, PED ? 1 : 0);
                chk("ped_La", La, 2);
                chk("ped_Lb", Lb, PED ? 2 : 0);
            end
            if (i == 34) chk("ped_walk_last", state, PED ? 4 : 2);
            if (i == 35) begin chk("ped_after", state, 2); chk("ped_after_walk", walk, 0); end
        end
        Ta = 1'b1; Tb = 1'b0;
        wait_state(3'd3, "ped_reach_BY");
        wait_state(3'd0, "ped_reach_AG");

        // Request held from A yellow through the walk phase: exactly one walk
        Ta = 1'b0; Tb = 1'b1;
        do_reset();
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (i == 11) ped_req = 1'b1;
            if (i == 35) ped_req = 1'b0;
            if (i == 36) begin Ta = 1'b1; Tb = 1'b0; end
            if (i == 15) chk("hold_ped_state", state, PED ? 4 : 2);
            if (i == 35) chk("hold_ped_exit", state, 2);
            if (i == 50) begin chk("hold_ped_single", state, 0); chk("hold_ped_walk", walk, 0); end
        end
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
